// File: rtl/pos_receipt_reader.sv
// rtl/pos_receipt_reader.sv - POS cart read-out: walks a snapshot of the item counts and streams receipt records
module pos_receipt_reader #(
  parameter logic [15:0] SUMMARY_ID = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] item_counts,
  output logic        busy,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [15:0] rec_item_id,
  output logic [3:0]  rec_qty,
  output logic [15:0] rec_line_total,
  output logic        rec_last,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SCAN, EMIT, SUM, SUMEMIT} state_t;

  state_t      state, nextState;
  logic [47:0] snapCounts;
  logic [3:0]  idx;
  logic [15:0] grandTotal;
  logic [3:0]  typeCount;
  logic [3:0]  curCount;
  logic [15:0] curId;
  logic [9:0]  curPrice;
  logic [15:0] curTotal;
  logic        accept;
  logic        lastIdx;
  logic        busyNext, validNext, lastNext, doneNext;

  // Catalogue lookup for the item currently addressed by idx
  always_comb begin
    curCount = snapCounts[{idx, 2'b00} +: 4];
    curId    = 16'd0;
    curPrice = 10'd0;
    case (idx)
      4'd0:  begin curId = 16'd3124; curPrice = 10'd250; end
      4'd1:  begin curId = 16'd4132; curPrice = 10'd50;  end
      4'd2:  begin curId = 16'd4133; curPrice = 10'd75;  end
      4'd3:  begin curId = 16'd3121; curPrice = 10'd200; end
      4'd4:  begin curId = 16'd3133; curPrice = 10'd100; end
      4'd5:  begin curId = 16'd3214; curPrice = 10'd995; end
      4'd6:  begin curId = 16'd1111; curPrice = 10'd450; end
      4'd7:  begin curId = 16'd2222; curPrice = 10'd300; end
      4'd8:  begin curId = 16'd3333; curPrice = 10'd400; end
      4'd9:  begin curId = 16'd4444; curPrice = 10'd600; end
      4'd10: begin curId = 16'd1122; curPrice = 10'd500; end
      4'd11: begin curId = 16'd3344; curPrice = 10'd150; end
      default: ;
    endcase
    curTotal = {6'd0, curPrice} * {12'd0, curCount};
    accept   = rec_valid && rec_ready;
    lastIdx  = (idx == 4'd11);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = SCAN;
      SCAN:    if (curCount != 4'd0) nextState = EMIT;
               else if (lastIdx)     nextState = SUM;
      EMIT:    if (accept) nextState = lastIdx ? SUM : SCAN;
      SUM:     nextState = SUMEMIT;
      SUMEMIT: if (accept) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Control outputs are registered from the upcoming state
  always_comb begin
    busyNext  = (nextState != IDLE);
    validNext = (nextState == EMIT) || (nextState == SUMEMIT);
    lastNext  = (nextState == SUMEMIT);
    doneNext  = (state == SUMEMIT) && accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapCounts     <= '0;
      idx            <= '0;
      grandTotal     <= '0;
      typeCount      <= '0;
      rec_item_id    <= '0;
      rec_qty        <= '0;
      rec_line_total <= '0;
      busy           <= 1'b0;
      rec_valid      <= 1'b0;
      rec_last       <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snapCounts <= item_counts;
          idx        <= '0;
          grandTotal <= '0;
          typeCount  <= '0;
        end
        SCAN: if (curCount != 4'd0) begin
          rec_item_id    <= curId;
          rec_qty        <= curCount;
          rec_line_total <= curTotal;
          grandTotal     <= grandTotal + curTotal;
          typeCount      <= typeCount + 4'd1;
        end else begin
          idx <= idx + 4'd1;
        end
        EMIT: if (accept) idx <= idx + 4'd1;
        SUM: begin
          rec_item_id    <= SUMMARY_ID;
          rec_qty        <= typeCount;
          rec_line_total <= grandTotal;
        end
        default: ;
      endcase
      busy      <= busyNext;
      rec_valid <= validNext;
      rec_last  <= lastNext;
      done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_pos_receipt_reader.sv
// tb/tb_pos_receipt_reader.sv - directed scoreboard bench for pos_receipt_reader
module tb_pos_receipt_reader;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  qty;
    logic [15:0] tot;
    logic        last;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [47:0] item_counts;
  logic        busy;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] rec_item_id;
  logic [3:0]  rec_qty;
  logic [15:0] rec_line_total;
  logic        rec_last;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  rec_t expQ[$];

  int CAT_ID[12]    = '{3124, 4132, 4133, 3121, 3133, 3214, 1111, 2222, 3333, 4444, 1122, 3344};
  int CAT_PRICE[12] = '{250, 50, 75, 200, 100, 995, 450, 300, 400, 600, 500, 150};

  pos_receipt_reader #(.SUMMARY_ID(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .item_counts(item_counts),
    .busy(busy), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_item_id(rec_item_id), .rec_qty(rec_qty), .rec_line_total(rec_line_total),
    .rec_last(rec_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void pushExpected(input logic [47:0] c);
    int   n;
    int   tot;
    int   q;
    rec_t r;
    n = 0;
    tot = 0;
    for (int i = 0; i < 12; i++) begin
      q = int'(c[4*i +: 4]);
      if (q != 0) begin
        r.id   = 16'(CAT_ID[i]);
        r.qty  = 4'(q);
        r.tot  = 16'(q * CAT_PRICE[i]);
        r.last = 1'b0;
        expQ.push_back(r);
        n++;
        tot += q * CAT_PRICE[i];
      end
    end
    r.id   = 16'hFFFF;
    r.qty  = 4'(n);
    r.tot  = 16'(tot);
    r.last = 1'b1;
    expQ.push_back(r);
  endfunction

  task automatic runReadout(input logic [47:0] counts, input int stall, input int expDone,
                            input bit disturb, output logic [15:0] sumTot);
    int   off, stallCnt, busyCycles;
    bit   fin, holding;
    rec_t obs, held, e;
    pushExpected(counts);
    sumTot = '0; stallCnt = 0; busyCycles = 0; fin = 0; holding = 0; held = '0;
    item_counts = counts;
    start = 1'b1;
    rec_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    off = 0;
    chk("busy_after_start", busy, 1);
    while (!fin && off < 600) begin
      obs = {rec_item_id, rec_qty, rec_line_total, rec_last};
      if (holding) begin
        chk("stall_valid_held", rec_valid, 1);
        chk("stall_fields_stable", obs, held);
      end
      if (done) begin
        chk("done_edge", off, expDone);
        chk("busy_span", busyCycles, expDone);
        fin = 1;
      end else begin
        if (busy) busyCycles++;
        holding = 0;
        if (rec_valid) begin
          if (stallCnt < stall) begin
            rec_ready = 1'b0;
            stallCnt++;
            holding = 1;
            held = obs;
          end else begin
            rec_ready = 1'b1;
            stallCnt = 0;
            if (expQ.size() == 0) chk("unexpected_record", 1, 0);
            else begin
              e = expQ.pop_front();
              chk("rec_item_id", obs.id, e.id);
              chk("rec_qty", obs.qty, e.qty);
              chk("rec_line_total", obs.tot, e.tot);
              chk("rec_last", obs.last, e.last);
              if (obs.last) sumTot = obs.tot;
            end
          end
        end else begin
          rec_ready = (stall == 0);
        end
        if (disturb && off == 3) begin
          start = 1'b1;
          item_counts = ~counts;
        end
        if (disturb && off == 4) start = 1'b0;
        @(posedge clk); @(negedge clk);
        off++;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("valid_after_done", rec_valid, 0);
    chk("queue_empty", expQ.size(), 0);
    expQ.delete();
  endtask

  logic [47:0] cartA = 48'h3000_0010_0040;
  logic [47:0] cartB = 48'h0070_0000_0002;
  logic [47:0] cartFull = 48'hFFFF_FFFF_FFFF;

  initial begin
    logic [15:0] sumTot;
    int accepts;
    bit found;
    rst_n = 1'b0; start = 1'b0; rec_ready = 1'b0; item_counts = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rec_valid, 0);
    chk("rst_item_id", rec_item_id, 0);
    chk("rst_qty", rec_qty, 0);
    chk("rst_line_total", rec_line_total, 0);
    chk("rst_last", rec_last, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    runReadout('0, 0, 14, 0, sumTot);
    chk("empty_total", sumTot, 0);

    runReadout(cartA, 0, 17, 0, sumTot);
    chk("cartA_total", sumTot, 1645);

    runReadout(cartA, 3, 29, 0, sumTot);
    chk("cartA_stall_total", sumTot, 1645);

    runReadout(cartFull, 0, 26, 0, sumTot);
    chk("full_total", sumTot, 61050);

    runReadout(cartB, 0, 16, 1, sumTot);
    chk("snapshot_total", sumTot, 2 * 250 + 7 * 600);

    // Reset while the second record of cartA is on offer
    item_counts = cartA; start = 1'b1; rec_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    accepts = 0; found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (rec_valid && accepts == 1) found = 1;
      else begin
        if (rec_valid && rec_ready) accepts++;
        @(posedge clk); @(negedge clk);
        if (accepts == 1) rec_ready = 1'b0;
      end
    end
    chk("second_record_reached", found, 1);
    chk("second_record_id", rec_item_id, 3214);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rec_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_item_id", rec_item_id, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_done", done, 0);
    runReadout(cartA, 0, 17, 0, sumTot);
    chk("postrst_total", sumTot, 1645);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pos_receipt_reader.md
# pos_receipt_reader

Read-out end of the POS cart. On a `start` pulse, snapshots the twelve per-item cart counts and walks them in fixed catalogue order. Emits one record per non-empty item type (barcode, quantity, line total) over a valid/ready stream, then a closing summary record carrying the grand total. Sits between the cart-update logic that writes the counts and the receipt/display sink.

## Interface
Parameters:
- `SUMMARY_ID`, default 16'hFFFF: barcode value that marks the summary record.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a read-out; sampled only in IDLE.
- `item_counts`  in  48  packed counts, 4 bits per item; index i occupies bits [4i+3:4i].
- `busy`  out  1  high from the cycle after an accepted `start` until the summary record is accepted.
- `rec_valid`  out  1  record present on the `rec_*` fields.
- `rec_ready`  in  1  sink accepts the record.
- `rec_item_id`  out  16  item barcode (decimal value), or `SUMMARY_ID`.
- `rec_qty`  out  4  item count; in the summary record, the number of non-empty item types.
- `rec_line_total`  out  16  qty × price in kurus; in the summary record, the grand total.
- `rec_last`  out  1  high only on the summary record.
- `done`  out  1  one-cycle pulse after the summary record is accepted.

## Operation
- Fixed catalogue, as index: ID/price.
  - 0 banana 3124/250, 1 potato 4132/50, 2 tomato 4133/75, 3 peach 3121/200
  - 4 apple 3133/100, 5 pineapple 3214/995, 6 orange 1111/450, 7 mandarin 2222/300
  - 8 cherry 3333/400, 9 grape 4444/600, 10 pear 1122/500, 11 cucumber 3344/150
- States: IDLE, SCAN, EMIT, SUM, SUMEMIT.
- IDLE:
  - `start`=1 → snapshot `item_counts`, clear index, grand total and type count → SCAN.
  - `start` in any other state is ignored.
  - Changes on `item_counts` after the snapshot have no effect.
- SCAN (one cycle per index):
  - count==0 → index+1; after index 11 → SUM.
  - count!=0 → load the record: line total = count × price, full 16-bit product. Add the line total to the grand total, increment the type count, assert `rec_valid` → EMIT.
- EMIT: hold the record; on `rec_valid && rec_ready` → index+1 → SCAN, or SUM if the index was 11.
- SUM: load the summary record (`rec_item_id`=`SUMMARY_ID`, `rec_qty`=type count, `rec_line_total`=grand total, `rec_last`=1), assert `rec_valid` → SUMEMIT.
- SUMEMIT: on accept → IDLE; `done`=1 for one cycle; `busy`=0.
- Width rule: max grand total is 15 × 4070 = 61050 < 2^16, so no overflow is possible and no saturation logic is needed. The type count is ≤ 12 and fits in 4 bits.
- Empty cart: only the summary record (qty 0, total 0) is emitted.

## Timing
- Reset values: `busy`=0, `rec_valid`=0, `rec_item_id`=0, `rec_qty`=0, `rec_line_total`=0, `rec_last`=0, `done`=0; state IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately. No partial record completes, and there is no `done` pulse.
- All outputs are registered. `rec_valid` never depends combinationally on `rec_ready`.
- While `rec_valid`=1 and `rec_ready`=0, all `rec_*` fields are held stable.
- `rec_ready` is ignored when `rec_valid`=0.
- Sequence with `start` sampled at edge k and `rec_ready` tied high, N non-empty items:
  - `busy`=1 after edge k.
  - Summary record valid after edge k+13+N.
  - `done` high for the cycle after edge k+14+N.
- Each cycle of back-pressure adds exactly one cycle.
- A `start` held high across the `done` cycle begins a new read-out, since the state is IDLE that cycle.

## Test plan
- Empty cart, ready high → exactly one record: {FFFF, qty 0, total 0, last 1}. `done` is high after edge k+14; `busy` spans 14 cycles.
- Counts potato=4, pineapple=1, cucumber=3, ready high → records in this order, then `done` after edge k+17:
  - {4132, 4, 200}
  - {3214, 1, 995}
  - {3344, 3, 450}
  - {FFFF, 3, 1645, last}
- Same cart with `rec_ready` low for 3 cycles on each record → fields stable throughout the stalls; same record sequence; `done` 12 cycles later than the previous test.
- All counts = 15 → 12 records, e.g. pineapple {3214, 15, 14925}; summary {FFFF, 12, 61050}.
- `start` re-pulsed while busy, and `item_counts` changed mid-scan → output is unaffected and matches the original snapshot.
- `rst_n` low during EMIT of the second record → `rec_valid`, `busy` and `done` go low at once. A new `start` after release produces the full sequence from index 0.
